mem_bus_responder: RTL and testbench

Memory-side responder for the DA_VINCI memory bus. Services READ/WRITE requests issued by the processor's memory interface against an internal synchronous SRAM window, with a programmable number of wait states and a single-cycle READY/ERR completion handshake. Used as a standalone memory target in unit benches and as the slave end of the bus in reduced-size system configurations.

---
 rtl/mem_bus_responder_pkg.sv | 45 ++++
 rtl/mem_bus_responder_if.sv | 37 +++
 rtl/mem_bus_responder_ram.sv | 36 +++
 rtl/mem_bus_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_responder_pkg
// Shared definitions for the memory bus responder:
//   - default data/address widths, window size and window base address
//   - wait-state counter width and its upper limit
//   - FSM state and latched-opcode encodings
//   - decode_op(): classifies the sampled READ/WRITE strobes
// No ports (package).
// -----------------------------------------------------------------------------
package mem_bus_responder_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH  = 26;
    localparam int unsigned DEFAULT_DEPTH_LOG2  = 8;
    localparam logic [DEFAULT_ADDR_WIDTH-1:0] DEFAULT_BASE_ADDR = 26'h3FFFF00;
    localparam int unsigned DEFAULT_WAIT_STATES = 2;

    localparam int unsigned WAIT_CNT_WIDTH  = 4;
    localparam int unsigned MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_HOLD
    } state_t;

    // OP_BAD marks READ and WRITE sampled high together.
    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_BAD
    } op_t;

    function automatic op_t decode_op(input logic read, input logic write);
        if (read && write) begin
            return OP_BAD;
        end
        if (write) begin
            return OP_WRITE;
        end
        return OP_READ;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// -----------------------------------------------------------------------------
// mem_bus_responder_if
// Memory bus between an initiator (master) and the responder (slave).
//   addr      word address of the request
//   read      read request strobe
//   write     write request strobe
//   data_in   write data from the initiator
//   data_out  read data returned to the initiator
//   ready     one-cycle completion pulse
//   err       qualifies ready: request failed
// -----------------------------------------------------------------------------
interface mem_bus_responder_if
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;
    logic                  err;

    modport master (
        output addr, read, write, data_in,
        input  data_out, ready, err
    );

    modport slave (
        input  addr, read, write, data_in,
        output data_out, ready, err
    );

endinterface

// File: rtl/mem_bus_responder_ram.sv
// -----------------------------------------------------------------------------
// mem_bus_responder_ram
// Single-port synchronous RAM with a registered read port.
//   clk    clock
//   en     access enable for this cycle
//   we     write enable (with en); otherwise en performs a read
//   addr   word index
//   wdata  write data
//   rdata  read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module mem_bus_responder_ram #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
// Memory-side responder: services READ/WRITE requests against an internal
// SRAM window at BASE_ADDR with WAIT_STATES extra cycles before a one-cycle
// ready pulse. Misses and READ+WRITE collisions complete with err set.
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset (memory contents are kept)
//   bus  slave end of the memory bus (addr/read/write/data_in in,
//        data_out/ready/err out)
// -----------------------------------------------------------------------------
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int unsigned           DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned           WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_bus_responder_if.slave       bus
);

    localparam longint unsigned WINDOW_END = longint'(BASE_ADDR) + (64'd1 << DEPTH_LOG2);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_WIDTH'(WAIT_STATES - 1);

    if (WINDOW_END > (64'd1 << ADDR_WIDTH)) begin : g_window_check
        $error("mem_bus_responder: decoded window runs past the top of the address space");
    end
    if (WAIT_STATES > MAX_WAIT_STATES) begin : g_wait_check
        $error("mem_bus_responder: WAIT_STATES out of range");
    end

    state_t                    state;
    state_t                    next_state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    op_t                       op_q;
    logic                      hit_q;
    logic [DEPTH_LOG2-1:0]     index_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     data_out_q;

    logic                      request;
    op_t                       bus_op;
    logic [ADDR_WIDTH-1:0]     bus_offset;
    logic                      bus_hit;
    logic                      commit;
    op_t                       cur_op;
    logic                      cur_hit;
    logic [DEPTH_LOG2-1:0]     cur_index;
    logic [DATA_WIDTH-1:0]     cur_data;
    logic                      ram_en;
    logic                      ram_we;
    logic [DATA_WIDTH-1:0]     ram_rdata;
    logic [DATA_WIDTH-1:0]     resp_data;
    logic                      resp_err;

    // Address decode of the live bus request (used when sampling in IDLE).
    assign request    = bus.read | bus.write;
    assign bus_op     = decode_op(bus.read, bus.write);
    assign bus_offset = bus.addr - BASE_ADDR;
    assign bus_hit    = (bus.addr >= BASE_ADDR) && ((bus_offset >> DEPTH_LOG2) == '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (request) begin
                    if (WAIT_STATES == 0) begin
                        next_state = ST_RESP;
                        commit     = 1'b1;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = ST_RESP;
                    commit     = 1'b1;
                end
            end
            ST_RESP: next_state = ST_HOLD;
            ST_HOLD: begin
                if (!request) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The RAM access happens on the edge entering RESP. With no wait states
    // that edge is the sampling edge, so the live bus values are used there;
    // otherwise the latched request is authoritative.
    assign cur_op    = (state == ST_IDLE) ? bus_op                        : op_q;
    assign cur_hit   = (state == ST_IDLE) ? bus_hit                       : hit_q;
    assign cur_index = (state == ST_IDLE) ? bus_offset[DEPTH_LOG2-1:0]    : index_q;
    assign cur_data  = (state == ST_IDLE) ? bus.data_in                   : data_q;

    // Reset on the committing edge aborts the request, so the write is gated.
    assign ram_en = commit & ~rst;
    assign ram_we = ram_en && (cur_op == OP_WRITE) && cur_hit;

    mem_bus_responder_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_index),
        .wdata (cur_data),
        .rdata (ram_rdata)
    );

    // Write responses leave the previously returned read data on the bus.
    always_comb begin
        resp_data = '0;
        if (op_q == OP_READ && hit_q) begin
            resp_data = ram_rdata;
        end else if (op_q == OP_WRITE) begin
            resp_data = data_out_q;
        end
    end

    assign resp_err     = (op_q == OP_BAD) || !hit_q;
    assign bus.ready    = (state == ST_RESP);
    assign bus.err      = (state == ST_RESP) && resp_err;
    assign bus.data_out = (state == ST_RESP) ? resp_data : data_out_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            op_q       <= OP_READ;
            hit_q      <= 1'b0;
            index_q    <= '0;
            data_q     <= '0;
            data_out_q <= '0;
        end else begin
            if (state == ST_IDLE && request) begin
                op_q     <= bus_op;
                hit_q    <= bus_hit;
                index_q  <= bus_offset[DEPTH_LOG2-1:0];
                data_q   <= bus.data_in;
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == ST_RESP) begin
                data_out_q <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_responder
// Directed bench for mem_bus_responder. Two instances share clk/rst: one with
// two wait states and one with none. Inputs are driven 1 ns after the rising
// edge and outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_mem_bus_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int err_leak    = 0;

    always #5 clk = ~clk;

    mem_bus_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) bus2 ();
    mem_bus_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) bus0 ();

    mem_bus_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (26),
        .DEPTH_LOG2 (8),
        .BASE_ADDR  (26'h3FFFF00),
        .WAIT_STATES(2)
    ) dut_ws2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    mem_bus_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (26),
        .DEPTH_LOG2 (8),
        .BASE_ADDR  (26'h3FFFF00),
        .WAIT_STATES(0)
    ) dut_ws0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [25:0] a, input logic [31:0] d);
        if (sel) begin
            bus0.read = rd; bus0.write = wr; bus0.addr = a; bus0.data_in = d;
        end else begin
            bus2.read = rd; bus2.write = wr; bus2.addr = a; bus2.data_in = d;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus0.ready : bus2.ready;
    endfunction

    function automatic logic erf(input bit sel);
        return sel ? bus0.err : bus2.err;
    endfunction

    function automatic logic [31:0] dout(input bit sel);
        return sel ? bus0.data_out : bus2.data_out;
    endfunction

    // Issue one request; lat counts edges from the sampling edge (1) to the
    // edge that starts the READY cycle. lat = 0 means no READY within budget.
    task automatic xfer(input bit sel, input logic rd, input logic wr,
                        input logic [25:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] data, output logic e);
        lat  = 0;
        data = '0;
        e    = 1'b0;
        drive(sel, rd, wr, a, d);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rdy(sel)) begin
                lat  = k;
                data = dout(sel);
                e    = erf(sel);
                break;
            end
            if (erf(sel)) err_leak++;
        end
        drive(sel, 1'b0, 1'b0, a, d);
        tick();
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          lat;
        logic [31:0] data;
        logic        e;
        int          pulses;

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_ready",    32'(bus2.ready),  32'd0);
        check("rst_err",      32'(bus2.err),    32'd0);
        check("rst_data_out", bus2.data_out,    32'd0);
        check("rst_ready_ws0", 32'(bus0.ready), 32'd0);

        // Write hit then read back, two wait states
        xfer(1'b0, 1'b0, 1'b1, 26'h3FFFF05, 32'hDEADBEEF, lat, data, e);
        check("wr_hit_lat", 32'(lat), 32'd3);
        check("wr_hit_err", 32'(e),   32'd0);
        xfer(1'b0, 1'b1, 1'b0, 26'h3FFFF05, 32'h0, lat, data, e);
        check("rd_hit_lat",  32'(lat), 32'd3);
        check("rd_hit_err",  32'(e),   32'd0);
        check("rd_hit_data", data,     32'hDEADBEEF);

        // Write response leaves the last read data on the bus
        xfer(1'b0, 1'b0, 1'b1, 26'h3FFFF10, 32'hA5A5A5A5, lat, data, e);
        check("wr_hold_data", data,   32'hDEADBEEF);
        check("wr_hold_err",  32'(e), 32'd0);

        // Out-of-window read and write
        xfer(1'b0, 1'b1, 1'b0, 26'h0000010, 32'h0, lat, data, e);
        check("rd_miss_lat",  32'(lat), 32'd3);
        check("rd_miss_err",  32'(e),   32'd1);
        check("rd_miss_data", data,     32'd0);
        xfer(1'b0, 1'b0, 1'b1, 26'h0000010, 32'h55555555, lat, data, e);
        check("wr_miss_err", 32'(e), 32'd1);
        xfer(1'b0, 1'b1, 1'b0, 26'h3FFFF10, 32'h0, lat, data, e);
        check("wr_miss_kept", data, 32'hA5A5A5A5);

        // READ and WRITE together is a protocol error
        xfer(1'b0, 1'b0, 1'b1, 26'h3FFFF00, 32'h11112222, lat, data, e);
        xfer(1'b0, 1'b1, 1'b1, 26'h3FFFF00, 32'h99999999, lat, data, e);
        check("both_lat",  32'(lat), 32'd3);
        check("both_err",  32'(e),   32'd1);
        check("both_data", data,     32'd0);
        xfer(1'b0, 1'b1, 1'b0, 26'h3FFFF00, 32'h0, lat, data, e);
        check("both_mem_kept", data, 32'h11112222);

        // READ held across completion: one pulse, then a second after a drop
        drive(1'b0, 1'b1, 1'b0, 26'h3FFFF05, 32'h0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus2.ready) pulses++;
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus2.ready) pulses++;
        end
        check("held_one_pulse", 32'(pulses), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 26'h3FFFF05, 32'h0);
        tick();
        xfer(1'b0, 1'b1, 1'b0, 26'h3FFFF05, 32'h0, lat, data, e);
        check("reassert_lat",  32'(lat), 32'd3);
        check("reassert_data", data,     32'hDEADBEEF);

        // Reset in the last WAIT cycle aborts the write
        xfer(1'b0, 1'b0, 1'b1, 26'h3FFFFFF, 32'hCAFEF00D, lat, data, e);
        xfer(1'b0, 1'b1, 1'b0, 26'h3FFFFFF, 32'h0, lat, data, e);
        check("top_word_data", data, 32'hCAFEF00D);
        drive(1'b0, 1'b0, 1'b1, 26'h3FFFFFF, 32'h12345678);
        tick();
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 26'h3FFFFFF, 32'h0);
        tick();
        check("rst_wait_ready",    32'(bus2.ready), 32'd0);
        check("rst_wait_err",      32'(bus2.err),   32'd0);
        check("rst_wait_data_out", bus2.data_out,   32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus2.ready) pulses++;
        end
        check("rst_wait_no_ready", 32'(pulses), 32'd0);
        xfer(1'b0, 1'b1, 1'b0, 26'h3FFFFFF, 32'h0, lat, data, e);
        check("rst_wait_mem_kept", data, 32'hCAFEF00D);

        // Zero-wait-state instance: window boundaries
        xfer(1'b1, 1'b0, 1'b1, 26'h3FFFF00, 32'h01010101, lat, data, e);
        check("ws0_wr_lo_lat", 32'(lat), 32'd1);
        check("ws0_wr_lo_err", 32'(e),   32'd0);
        xfer(1'b1, 1'b0, 1'b1, 26'h3FFFFFF, 32'hFEFEFEFE, lat, data, e);
        check("ws0_wr_hi_err", 32'(e), 32'd0);
        xfer(1'b1, 1'b1, 1'b0, 26'h3FFFF00, 32'h0, lat, data, e);
        check("ws0_rd_lo_lat",  32'(lat), 32'd1);
        check("ws0_rd_lo_err",  32'(e),   32'd0);
        check("ws0_rd_lo_data", data,     32'h01010101);
        xfer(1'b1, 1'b1, 1'b0, 26'h3FFFFFF, 32'h0, lat, data, e);
        check("ws0_rd_hi_err",  32'(e), 32'd0);
        check("ws0_rd_hi_data", data,   32'hFEFEFEFE);
        xfer(1'b1, 1'b1, 1'b0, 26'h3FFFEFF, 32'h0, lat, data, e);
        check("ws0_rd_below_lat",  32'(lat), 32'd1);
        check("ws0_rd_below_err",  32'(e),   32'd1);
        check("ws0_rd_below_data", data,     32'd0);
        xfer(1'b1, 1'b0, 1'b1, 26'h3FFFEFF, 32'h77777777, lat, data, e);
        check("ws0_wr_below_err", 32'(e), 32'd1);
        xfer(1'b1, 1'b1, 1'b0, 26'h3FFFFFF, 32'h0, lat, data, e);
        check("ws0_wr_below_kept", data, 32'hFEFEFEFE);

        // err must never be seen without ready
        check("err_without_ready", 32'(err_leak), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
